// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of the UART TX FIFO write port.
// A granted requester keeps the port until it writes a byte flagged last, or until it
// leaves valid low for MAX_STALL locked cycles, at which point the lock is forcibly released.
// The write path is zero-latency: the owner's byte goes straight to the FIFO.
module uart_tx_arbiter #(
    parameter int unsigned BUS_SIZE  = 8,
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned MAX_STALL = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*BUS_SIZE-1:0] i_req_data,
    input  logic [N_REQ-1:0]          i_req_last,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      tx_full_signal,
    output logic [BUS_SIZE-1:0]       o_tx_data,
    output logic                      wr_signal,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_STALL + 1);

    // Pointer resets to the highest index so requester 0 is searched first.
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_REQ - 1);
    // The stall count reaches MAX_STALL on the cycle this value is seen with valid low.
    localparam logic [CntW-1:0] StallLimit = CntW'(MAX_STALL - 1);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   stall_q, stall_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              lock_open;
    logic [N_REQ-1:0]  ready;
    logic              transfer;
    logic              owner_valid;
    logic              owner_last;
    logic [BUS_SIZE-1:0] owner_data;

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;
    logic [N_REQ-1:0]  win_onehot;

    // Owner-side view: AND-OR select through the one-hot grant, all zero when idle.
    always_comb begin
        owner_valid = |(i_req_valid & grant_q);
        owner_last  = |(i_req_last & grant_q);
        owner_data  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant_q[k]) begin
                owner_data = owner_data | i_req_data[k*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

    // Port handshake: only the owner sees ready, never while the FIFO is full or in reset.
    always_comb begin
        lock_open   = (state_q == StLocked) && !tx_full_signal && !reset;
        ready       = grant_q & {N_REQ{lock_open}};
        transfer    = |(ready & i_req_valid);
        o_req_ready = ready;
        wr_signal   = transfer;
        o_tx_data   = owner_data;
        o_grant     = grant_q;
        o_busy      = busy_q;
        o_timeout   = timeout_q;
    end

    // Round-robin search: first valid index strictly after the pointer, wrapping.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = IdxW'((int'(ptr_q) + i) % int'(N_REQ));
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    // Next-state: grant on any valid in idle; release on last byte or stall expiry.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        stall_d   = stall_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StLocked;
                    grant_d = win_onehot;
                    owner_d = win_idx;
                    stall_d = '0;
                    busy_d  = 1'b1;
                end
            end
            StLocked: begin
                if (transfer) begin
                    stall_d = '0;
                    if (owner_last) begin
                        state_d = StIdle;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        ptr_d   = owner_q;
                    end
                end else if (!owner_valid) begin
                    // Cycles blocked only by a full FIFO (valid high) fall through untouched.
                    if (stall_q == StallLimit) begin
                        state_d   = StIdle;
                        grant_d   = '0;
                        busy_d    = 1'b0;
                        ptr_d     = owner_q;
                        stall_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; the lock drops at the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= LastIdx;
            stall_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the two-requester TX FIFO arbiter.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
module tb_uart_tx_arbiter;

    localparam int unsigned BUS_SIZE  = 8;
    localparam int unsigned N_REQ     = 2;
    localparam int unsigned MAX_STALL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_req_valid;
    logic [15:0] i_req_data;
    logic [1:0]  i_req_last;
    logic [1:0]  o_req_ready;
    logic        tx_full_signal;
    logic [7:0]  o_tx_data;
    logic        wr_signal;
    logic [1:0]  o_grant;
    logic        o_busy;
    logic        o_timeout;

    int errors = 0;
    int checks = 0;

    // Control outputs packed as {grant, busy, timeout, ready, wr}.
    logic [6:0] ctl;
    logic [6:0] exp_c;
    assign ctl = {o_grant, o_busy, o_timeout, o_req_ready, wr_signal};

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .BUS_SIZE (BUS_SIZE),
        .N_REQ    (N_REQ),
        .MAX_STALL(MAX_STALL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ready   (o_req_ready),
        .tx_full_signal(tx_full_signal),
        .o_tx_data     (o_tx_data),
        .wr_signal     (wr_signal),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    function automatic logic [6:0] c(input logic [1:0] g, input logic b, input logic t,
                                     input logic [1:0] r, input logic w);
        return {g, b, t, r, w};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        i_req_valid    = '0;
        i_req_last     = '0;
        i_req_data     = '0;
        tx_full_signal = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        i_req_valid    = '0;
        i_req_last     = '0;
        i_req_data     = 16'hC3A5;
        tx_full_signal = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, exp_c);
        end
        checks++;
        if (o_tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h expected 00", o_tx_data);
        end
        reset = 1'b0;
        next_cycle();
        #1;
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL reset_idle_ctl: got %b expected %b", ctl, exp_c);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        i_req_valid = 2'b01;
        i_req_data  = {8'h00, 8'h11};
        i_req_last  = 2'b00;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL single_arb: got %b expected %b", ctl, exp_c);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            i_req_data[7:0] = bytes[i];
            i_req_last[0]   = (i == 2);
            #1;
            exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL single_ctl%0d: got %b expected %b", i, ctl, exp_c);
            end
            checks++;
            if (o_tx_data !== bytes[i]) begin
                errors++;
                $display("FAIL single_data%0d: got %h expected %h", i, o_tx_data, bytes[i]);
            end
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL single_release: got %b expected %b", ctl, exp_c);
        end
    endtask

    task automatic test_round_robin();
        // Per cycle: expected grant and data after C0 (grant 00 means an idle cycle).
        logic [1:0] eg [6];
        logic [7:0] ed [6];
        eg[0] = 2'b01; ed[0] = 8'hA0;
        eg[1] = 2'b01; ed[1] = 8'hA1;
        eg[2] = 2'b00; ed[2] = 8'h00;
        eg[3] = 2'b10; ed[3] = 8'hB0;
        eg[4] = 2'b00; ed[4] = 8'h00;
        eg[5] = 2'b01; ed[5] = 8'hC0;
        do_reset();
        i_req_valid = 2'b11;
        i_req_data  = {8'hB0, 8'hA0};
        i_req_last  = 2'b10;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 1) begin
                i_req_data[7:0] = 8'hA1;
                i_req_last[0]   = 1'b1;
            end
            if (i == 2) i_req_data[7:0] = 8'hC0;
            if (i == 5) i_req_valid = 2'b01;
            #1;
            exp_c = (eg[i] == 2'b00) ? c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0)
                                     : c(eg[i], 1'b1, 1'b0, eg[i], 1'b1);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL rr_ctl%0d: got %b expected %b", i, ctl, exp_c);
            end
            checks++;
            if (o_tx_data !== ed[i]) begin
                errors++; $display("FAIL rr_data%0d: got %h expected %h", i, o_tx_data, ed[i]);
            end
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
    endtask

    task automatic test_no_interleave();
        do_reset();
        i_req_valid = 2'b10;
        i_req_data  = {8'hD1, 8'h00};
        i_req_last  = 2'b00;
        next_cycle();
        i_req_valid = 2'b11;
        i_req_data  = {8'hD1, 8'hE0};
        i_req_last  = 2'b01;
        #1;
        exp_c = c(2'b10, 1'b1, 1'b0, 2'b10, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'hD1) begin
            errors++; $display("FAIL noint_first: got %b/%h expected %b/d1", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_data[15:8] = 8'hD2;
        #1;
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'hD2) begin
            errors++; $display("FAIL noint_second: got %b/%h expected %b/d2", ctl, o_tx_data, exp_c);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            i_req_valid[1] = 1'b0;
            #1;
            exp_c = c(2'b10, 1'b1, 1'b0, 2'b10, 1'b0);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL noint_gap%0d: got %b expected %b", i, ctl, exp_c);
            end
        end
        next_cycle();
        i_req_valid[1]   = 1'b1;
        i_req_data[15:8] = 8'hD3;
        i_req_last[1]    = 1'b1;
        #1;
        exp_c = c(2'b10, 1'b1, 1'b0, 2'b10, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'hD3) begin
            errors++; $display("FAIL noint_last: got %b/%h expected %b/d3", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_valid[1] = 1'b0;
        i_req_last[1]  = 1'b0;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL noint_idle: got %b expected %b", ctl, exp_c);
        end
        next_cycle();
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'hE0) begin
            errors++; $display("FAIL noint_req0: got %b/%h expected %b/e0", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
    endtask

    task automatic test_tx_full();
        do_reset();
        i_req_valid = 2'b01;
        i_req_data  = {8'h00, 8'h01};
        i_req_last  = 2'b00;
        next_cycle();
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h01) begin
            errors++; $display("FAIL full_first: got %b/%h expected %b/01", ctl, o_tx_data, exp_c);
        end
        // Short block: 5 full cycles with 0x5A held.
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            i_req_data[7:0] = 8'h5A;
            tx_full_signal  = 1'b1;
            #1;
            exp_c = c(2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL full_hold%0d: got %b expected %b", i, ctl, exp_c);
            end
        end
        next_cycle();
        tx_full_signal = 1'b0;
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h5A) begin
            errors++; $display("FAIL full_drop: got %b/%h expected %b/5a", ctl, o_tx_data, exp_c);
        end
        // Long block beyond MAX_STALL: full with valid high must never time out.
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            i_req_data[7:0] = 8'h6B;
            i_req_last[0]   = 1'b1;
            tx_full_signal  = 1'b1;
            #1;
            exp_c = c(2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL full_long%0d: got %b expected %b", i, ctl, exp_c);
            end
        end
        next_cycle();
        tx_full_signal = 1'b0;
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h6B) begin
            errors++; $display("FAIL full_long_drop: got %b/%h expected %b/6b", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL full_release: got %b expected %b", ctl, exp_c);
        end
    endtask

    task automatic test_stall_timeout();
        do_reset();
        i_req_valid = 2'b11;
        i_req_data  = {8'h81, 8'h71};
        i_req_last  = 2'b10;
        next_cycle();
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h71) begin
            errors++; $display("FAIL stall_first: got %b/%h expected %b/71", ctl, o_tx_data, exp_c);
        end
        // MAX_STALL locked cycles with valid low: still owned on the last of them.
        for (int i = 0; i < int'(MAX_STALL); i++) begin
            next_cycle();
            i_req_valid[0] = 1'b0;
            #1;
            exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b0);
            checks++;
            if (ctl !== exp_c) begin
                errors++; $display("FAIL stall_hold%0d: got %b expected %b", i, ctl, exp_c);
            end
        end
        next_cycle();
        #1;
        exp_c = c(2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h00) begin
            errors++; $display("FAIL stall_timeout: got %b/%h expected %b/00", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        #1;
        exp_c = c(2'b10, 1'b1, 1'b0, 2'b10, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h81) begin
            errors++; $display("FAIL stall_next_req: got %b/%h expected %b/81", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL stall_after: got %b expected %b", ctl, exp_c);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        i_req_valid = 2'b11;
        i_req_data  = {8'hA1, 8'h91};
        i_req_last  = 2'b10;
        next_cycle();
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h91) begin
            errors++; $display("FAIL rstmid_first: got %b/%h expected %b/91", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_data[7:0] = 8'h92;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_req_ready, wr_signal} !== 3'b000) begin
            errors++; $display("FAIL rstmid_nowrite: got %b expected 000", {o_req_ready, wr_signal});
        end
        next_cycle();
        reset = 1'b0;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_idle: got %b/%h expected %b/00", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_last[0] = 1'b1;
        #1;
        exp_c = c(2'b01, 1'b1, 1'b0, 2'b01, 1'b1);
        checks++;
        if (ctl !== exp_c || o_tx_data !== 8'h92) begin
            errors++; $display("FAIL rstmid_req0: got %b/%h expected %b/92", ctl, o_tx_data, exp_c);
        end
        next_cycle();
        i_req_valid = 2'b00;
        i_req_last  = 2'b00;
        #1;
        exp_c = c(2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ctl !== exp_c) begin
            errors++; $display("FAIL rstmid_end: got %b expected %b", ctl, exp_c);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_tx_full();
        test_stall_timeout();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
